// File: rtl/decode_stage.sv
// decode_stage: DEPTH-entry instruction queue feeding an RV32/RV64 decoder with a registered valid/ready output.
// Optional DECODE_STATS_EN adds o_issue_cnt/o_illegal_cnt handshake counters.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_immediate,
  output logic [4:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [1:0]      o_wb_mux,
  output logic [11:0]     o_ctrl
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]     o_issue_cnt,
  output logic [31:0]     o_illegal_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit W64 = (XLEN == 64);
  localparam logic [4:0] OP_LOAD = 5'b00000, OP_OPI = 5'b00100, OP_AUIPC = 5'b00101,
    OP_STORE = 5'b01000, OP_OP = 5'b01100, OP_LUI = 5'b01101, OP_BR = 5'b11000,
    OP_JALR = 5'b11001, OP_JAL = 5'b11011, OP_SYS = 5'b11100, OP_OPI32 = 5'b00110,
    OP_OP32 = 5'b01110;

  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, load;
  logic [31:0]     ins, imm32;
  logic [4:0]      op;
  logic is_load, is_opi, is_auipc, is_store, is_op, is_lui, is_br, is_jalr, is_jal, is_sys;
  logic is_opi32, is_op32, legal, jump, wb, hz_rs1, hz_rs2;
  logic [XLEN-1:0] d_imm;
  logic [11:0]     d_ctrl;
  logic [1:0]      d_wb_mux;

  assign o_ready = count != CW'(DEPTH);
  assign push    = i_valid && o_ready && !i_flush;
  assign load    = count != '0 && (!o_valid || i_ready);

  always_comb begin
    ins      = q_instr[rd_ptr];
    op       = ins[6:2];
    is_load  = op == OP_LOAD;
    is_opi   = op == OP_OPI;
    is_auipc = op == OP_AUIPC;
    is_store = op == OP_STORE;
    is_op    = op == OP_OP;
    is_lui   = op == OP_LUI;
    is_br    = op == OP_BR;
    is_jalr  = op == OP_JALR;
    is_jal   = op == OP_JAL;
    is_sys   = op == OP_SYS;
    is_opi32 = W64 && op == OP_OPI32;
    is_op32  = W64 && op == OP_OP32;
    legal    = ins[1:0] == 2'b11 && (is_load || is_opi || is_auipc || is_store || is_op ||
               is_lui || is_br || is_jalr || is_jal || is_sys || is_opi32 || is_op32);
    jump     = is_jal || is_jalr;
    wb       = is_load || is_opi || is_auipc || is_op || is_lui || jump || is_opi32 || is_op32;
    hz_rs1   = is_load || is_opi || is_store || is_op || is_br || is_jalr || is_sys || is_opi32 || is_op32;
    hz_rs2   = is_br || is_store || is_op || is_op32;
    imm32    = !legal ? 32'd0 :
               (is_lui || is_auipc) ? {ins[31:12], 12'd0} :
               is_jal ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
               is_br ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
               is_store ? {{21{ins[31]}}, ins[30:25], ins[11:7]} :
               (is_load || is_opi || is_jalr || is_sys || is_opi32) ? {{21{ins[31]}}, ins[30:20]} : 32'd0;
    d_imm    = XLEN'($signed(imm32));
    d_wb_mux = is_load ? 2'b01 : jump ? 2'b10 : 2'b00;
    d_ctrl   = {!legal, is_sys, hz_rs2, hz_rs1, wb && legal, is_load && legal, is_store && legal,
                is_op || is_opi || is_opi32 || is_op32, !(is_op || is_op32),
                is_auipc || is_jal || is_br, jump && legal, is_br && legal};
  end

  always_ff @(posedge i_clk)
    if (push) begin
      q_instr[wr_ptr] <= i_instr;
      q_pc[wr_ptr]    <= i_pc;
    end

  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_immediate <= '0;
      o_opcode    <= '0;
      o_funct3    <= '0;
      o_funct7    <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_rd        <= '0;
      o_wb_mux    <= '0;
      o_ctrl      <= '0;
    end else if (i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      o_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(load);
      count  <= count + CW'(push) - CW'(load);
      if (load) begin
        o_valid     <= 1'b1;
        o_pc        <= q_pc[rd_ptr];
        o_immediate <= d_imm;
        o_opcode    <= op;
        o_funct3    <= ins[14:12];
        o_funct7    <= ins[31:25];
        o_rs1       <= is_lui ? 5'd0 : ins[19:15];
        o_rs2       <= ins[24:20];
        o_rd        <= ins[11:7];
        o_wb_mux    <= d_wb_mux;
        o_ctrl      <= d_ctrl;
      end else if (i_ready) o_valid <= 1'b0;
    end

`ifdef DECODE_STATS_EN
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_issue_cnt   <= '0;
      o_illegal_cnt <= '0;
    end else if (o_valid && i_ready) begin
      o_issue_cnt   <= o_issue_cnt + 32'd1;
      o_illegal_cnt <= o_illegal_cnt + 32'(o_ctrl[11]);
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage at XLEN=32 and XLEN=64 side by side.
module tb_decode_stage;
  logic clk = 0, rst_n = 0, flush = 0, valid = 0, ready = 0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  int n_chk = 0, n_fail = 0;

  logic a_rdy, a_vld, b_rdy, b_vld;
  logic [31:0] a_pc, a_imm;
  logic [63:0] b_pc, b_imm;
  logic [4:0] a_opc, a_rs1, a_rs2, a_rd, b_opc, b_rs1, b_rs2, b_rd;
  logic [2:0] a_f3, b_f3;
  logic [6:0] a_f7, b_f7;
  logic [1:0] a_wbm, b_wbm;
  logic [11:0] a_ctrl, b_ctrl;
`ifdef DECODE_STATS_EN
  logic [31:0] a_iss, a_ill, b_iss, b_ill;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(4)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(a_rdy),
    .i_instr(instr), .i_pc(pc[31:0]), .o_valid(a_vld), .i_ready(ready), .o_pc(a_pc),
    .o_immediate(a_imm), .o_opcode(a_opc), .o_funct3(a_f3), .o_funct7(a_f7), .o_rs1(a_rs1),
    .o_rs2(a_rs2), .o_rd(a_rd), .o_wb_mux(a_wbm), .o_ctrl(a_ctrl)
`ifdef DECODE_STATS_EN
    , .o_issue_cnt(a_iss), .o_illegal_cnt(a_ill)
`endif
  );

  decode_stage #(.XLEN(64), .DEPTH(4)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(b_rdy),
    .i_instr(instr), .i_pc(pc), .o_valid(b_vld), .i_ready(ready), .o_pc(b_pc),
    .o_immediate(b_imm), .o_opcode(b_opc), .o_funct3(b_f3), .o_funct7(b_f7), .o_rs1(b_rs1),
    .o_rs2(b_rs2), .o_rd(b_rd), .o_wb_mux(b_wbm), .o_ctrl(b_ctrl)
`ifdef DECODE_STATS_EN
    , .o_issue_cnt(b_iss), .o_illegal_cnt(b_ill)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p);
    valid = 1; instr = i; pc = p;
    step();
    valid = 0;
  endtask

  initial begin
    ready = 1;
    step(); step();
    chk("rst_valid", a_vld, 0);
    chk("rst_ready", a_rdy, 1);
    chk("rst_ctrl", a_ctrl, 0);
    chk("rst_imm64", b_imm, 0);
    rst_n = 1;

    push(32'h00500093, 64'h100);
    chk("addi_latency", a_vld, 0);
    step();
    chk("addi_valid", a_vld, 1);
    chk("addi_pc", a_pc, 32'h100);
    chk("addi_imm", a_imm, 5);
    chk("addi_rd", a_rd, 1);
    chk("addi_rs1", a_rs1, 0);
    chk("addi_opc", a_opc, 5'b00100);
    chk("addi_ctrl", a_ctrl, 12'h198);
    chk("addi_ctrl64", b_ctrl, 12'h198);
    step();
    chk("drain_valid", a_vld, 0);

    push(32'h12345137, 64'h104); step();
    chk("lui_imm", a_imm, 32'h12345000);
    chk("lui_rs1", a_rs1, 0);
    chk("lui_rd", a_rd, 2);
    chk("lui_hz_rs1", a_ctrl[8], 0);
    chk("lui_wb", a_ctrl[7], 1);
    push(32'h800000B7, 64'h108); step();
    chk("lui_neg32", a_imm, 32'h80000000);
    chk("lui_neg64", b_imm, 64'hFFFFFFFF80000000);

    push(32'h008000EF, 64'h10C); step();
    chk("jal_imm", a_imm, 8);
    chk("jal_jump", a_ctrl[1], 1);
    chk("jal_wbmux", a_wbm, 2'b10);
    push(32'h00208463, 64'h110); step();
    chk("beq_imm", a_imm, 8);
    chk("beq_branch", a_ctrl[0], 1);
    chk("beq_hz_rs2", a_ctrl[9], 1);
    chk("beq_rs2", a_rs2, 2);
    chk("beq_f3", a_f3, 0);

    push(32'h00000000, 64'h114); step();
    chk("zero_illegal", a_ctrl[11], 1);
    chk("zero_wb", a_ctrl[7], 0);
    chk("zero_mard", a_ctrl[6], 0);
    chk("zero_imm", a_imm, 0);
    chk("zero_valid", a_vld, 1);
    push(32'h0010809B, 64'h118); step();
    chk("addiw32_illegal", a_ctrl[11], 1);
    chk("addiw32_imm", a_imm, 0);
    chk("addiw64_illegal", b_ctrl[11], 0);
    chk("addiw64_imm", b_imm, 1);
    chk("addiw64_rs1", b_rs1, 1);
    chk("addiw64_rd", b_rd, 1);
    chk("addiw64_alu_en", b_ctrl[4], 1);
    step();

    ready = 0;
    for (int i = 0; i < 6; i++) push(32'h00000013 | ((i + 1) << 7), 64'h200 + 4 * i);
    chk("full_ready", a_rdy, 0);
    chk("full_ready64", b_rdy, 0);
    chk("full_valid", a_vld, 1);
    chk("full_head", a_pc, 32'h200);
    step();
    chk("stall_pc", a_pc, 32'h200);
    chk("stall_rd", a_rd, 1);
    ready = 1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("drain_pc", a_pc, 32'h200 + 4 * i);
      chk("drain_rd", a_rd, i + 1);
      chk("drain_vld", a_vld, 1);
    end
    step();
    chk("drain_end", a_vld, 0);
    chk("drain_rdy", a_rdy, 1);

    ready = 0;
    for (int i = 0; i < 4; i++) push(32'h00000013, 64'h300 + 4 * i);
    chk("preflush_valid", a_vld, 1);
    valid = 1; flush = 1; instr = 32'h00500093; pc = 64'h400;
    step();
    valid = 0; flush = 0;
    chk("flush_valid", a_vld, 0);
    chk("flush_ready", a_rdy, 1);
    ready = 1;
    step(); step();
    chk("flush_empty", a_vld, 0);
    chk("flush_empty64", b_vld, 0);

`ifdef DECODE_STATS_EN
    rst_n = 0; step(); rst_n = 1;
    chk("stats_rst", a_iss, 0);
    push(32'h00500093, 64'h500);
    push(32'h00000000, 64'h504);
    push(32'h12345137, 64'h508);
    push(32'hFFFFFFFF, 64'h50C);
    push(32'h00208463, 64'h510);
    step(); step(); step();
    chk("stats_issue", a_iss, 5);
    chk("stats_illegal", a_ill, 2);
    chk("stats_issue64", b_iss, 5);
    chk("stats_illegal64", b_ill, 2);
    flush = 1; step(); flush = 0; step();
    chk("stats_flush_issue", a_iss, 5);
    chk("stats_flush_illegal", a_ill, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
